c432_resp_analyzer: RTL

Output-response analyzer sitting directly downstream of the c432 benchmark wrapper, consuming its 7-bit `out_val` once per applied test vector. It compacts a fixed-length run of responses into a 16-bit MISR signature and compares the final signature against a golden value to flag Trojan-induced deviations. A small FSM bounds each run with a start/done handshake.

---
 rtl/c432_pkg.sv | 19 +
 rtl/c432_misr.sv | 40 ++++
 rtl/c432_resp_analyzer.sv | 128 ++++++++++++
 3 files changed

// File: rtl/c432_pkg.sv
// c432 response analyzer shared definitions: FSM states, MISR taps, default seed.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package c432_pkg;

    // Run-control FSM states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Feedback taps in mask form: bits 15, 13, 12, 10.
    localparam logic [15:0] MISR_TAP = 16'hB400;

    // Signature value loaded at the start of every run unless overridden.
    localparam logic [15:0] DEF_SEED = 16'h0000;

endpackage

// File: rtl/c432_misr.sv
// Multiple-input signature register: shift left, tap-parity feedback into bit 0, XOR data in.
// Latency: one cycle from en_i/load_i to sig_o; sig_next_o is combinational.
// Backpressure: none; absorbs data_i on every cycle en_i is high.
//
// Ports: clk_i/rst_i (async active-high), load_i loads seed_i (wins over en_i),
//        en_i absorbs data_i, sig_o current contents, sig_next_o value after an en_i cycle.
module c432_misr
    import c432_pkg::*;
#(
    parameter int                SIG_W = 16,
    parameter logic [SIG_W-1:0]  TAP   = SIG_W'(MISR_TAP)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic              en_i,
    input  logic [SIG_W-1:0]  seed_i,
    input  logic [SIG_W-1:0]  data_i,
    output logic [SIG_W-1:0]  sig_o,
    output logic [SIG_W-1:0]  sig_next_o
);

    logic [SIG_W-1:0] sig_q;
    logic             fb;

    assign fb         = ^(sig_q & TAP);
    assign sig_next_o = {sig_q[SIG_W-2:0], fb} ^ data_i;
    assign sig_o      = sig_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sig_q <= '0;
        end else if (load_i) begin
            sig_q <= seed_i;
        end else if (en_i) begin
            sig_q <= sig_next_o;
        end
    end

endmodule

// File: rtl/c432_resp_analyzer.sv
// c432 output-response analyzer: compacts NUM_VEC responses into a MISR signature and checks it against golden_sig.
// Latency: signature visible one cycle after its beat; done/pass one cycle after the final beat.
// Backpressure: none; every resp_valid beat in RUN is absorbed.
//
// Ports: clk, rst (async active-high); start, resp_valid, resp, golden_sig in;
//        busy, done, pass, signature, vec_count out.
// Optional macro C432_RESP_XCHK_EN adds exp_resp in, err_seen / first_err_idx out
// (per-beat compare against an expected response, first mismatch index latched).
module c432_resp_analyzer
    import c432_pkg::*;
#(
    parameter int                RESP_W  = 7,
    parameter int                SIG_W   = 16,
    parameter int                NUM_VEC = 1024,
    parameter logic [SIG_W-1:0]  SEED    = SIG_W'(DEF_SEED),
    localparam int               CNT_W   = $clog2(NUM_VEC + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               resp_valid,
    input  logic [RESP_W-1:0]  resp,
    input  logic [SIG_W-1:0]   golden_sig,
`ifdef C432_RESP_XCHK_EN
    input  logic [RESP_W-1:0]  exp_resp,
    output logic               err_seen,
    output logic [CNT_W-1:0]   first_err_idx,
`endif
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [SIG_W-1:0]   signature,
    output logic [CNT_W-1:0]   vec_count
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_VEC - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pass_q, pass_d;
    logic             start_ok;
    logic             beat;
    logic [SIG_W-1:0] sig_next;

    // start is ignored while a run is in progress; a beat coinciding with an
    // accepted start is dropped because the FSM is not yet in RUN.
    assign start_ok = start && (state_q != ST_RUN);
    assign beat     = (state_q == ST_RUN) && resp_valid;

    c432_misr #(
        .SIG_W (SIG_W)
    ) u_misr (
        .clk_i      (clk),
        .rst_i      (rst),
        .load_i     (start_ok),
        .en_i       (beat),
        .seed_i     (SEED),
        .data_i     (SIG_W'(resp)),
        .sig_o      (signature),
        .sig_next_o (sig_next)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pass_d  = pass_q;
        if (start_ok) begin
            state_d = ST_RUN;
            cnt_d   = '0;
            pass_d  = 1'b0;
        end else if (beat) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_IDX) begin
                state_d = ST_DONE;
                // Compare the signature that this final beat produces.
                pass_d  = (sig_next == golden_sig);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pass_q  <= pass_d;
        end
    end

    assign busy      = (state_q == ST_RUN);
    assign done      = (state_q == ST_DONE);
    assign pass      = pass_q;
    assign vec_count = cnt_q;

`ifdef C432_RESP_XCHK_EN
    logic             err_q, err_d;
    logic [CNT_W-1:0] err_idx_q, err_idx_d;

    always_comb begin
        err_d     = err_q;
        err_idx_d = err_idx_q;
        if (start_ok) begin
            err_d     = 1'b0;
            err_idx_d = '0;
        end else if (beat && !err_q && (resp != exp_resp)) begin
            err_d     = 1'b1;
            err_idx_d = cnt_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q     <= 1'b0;
            err_idx_q <= '0;
        end else begin
            err_q     <= err_d;
            err_idx_q <= err_idx_d;
        end
    end

    assign err_seen      = err_q;
    assign first_err_idx = err_idx_q;
`endif

endmodule
